// File: rtl/program_memory.sv
// Byte-loadable instruction memory: a program image is streamed in over a
// valid/ready port, then little-endian 32-bit words are fetched with one cycle latency.
module program_memory #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    input  logic [7:0]            load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    input  logic                  reload,
    input  logic                  fetch_en,
    input  logic [ADDR_WIDTH-1:0] PC,
    output logic [31:0]           Instruction_Code,
    output logic                  instr_valid,
    output logic                  fetch_fault,
    output logic                  mem_ready,
    output logic [ADDR_WIDTH:0]   load_count
);

    localparam int                  DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [31:0]           code_q, code_d;
    logic                  valid_q, valid_d;
    logic                  fault_q, fault_d;

    logic [7:0]            mem [DEPTH];

    logic                  xfer_s;
    logic [ADDR_WIDTH:0]   count_inc_s;
    logic [ADDR_WIDTH:0]   pc_end_s;
    logic                  fault_s;
    logic [31:0]           word_s;

    function automatic logic [31:0] assemble_word(
        input logic [7:0] b0,
        input logic [7:0] b1,
        input logic [7:0] b2,
        input logic [7:0] b3
    );
        return {b3, b2, b1, b0};
    endfunction

    // Handshake decode depends only on registered state, never on load_valid.
    assign load_ready  = (state_q == ST_LOAD) && (count_q < DEPTH_C);
    assign mem_ready   = (state_q == ST_RUN);
    assign xfer_s      = load_ready && load_valid;
    assign count_inc_s = count_q + (ADDR_WIDTH + 1)'(1);

    // One extra bit keeps PC+4 from wrapping, so the top word is legal only when full.
    assign pc_end_s = {1'b0, PC} + (ADDR_WIDTH + 1)'(4);
    assign fault_s  = (PC[1:0] != 2'b00) || (pc_end_s > count_q);
    assign word_s   = assemble_word(mem[PC],
                                    mem[PC + ADDR_WIDTH'(1)],
                                    mem[PC + ADDR_WIDTH'(2)],
                                    mem[PC + ADDR_WIDTH'(3)]);

    // Next-state for the load/run sequencer and the registered fetch result.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        code_d  = code_q;
        valid_d = 1'b0;
        fault_d = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (xfer_s) begin
                    count_d = count_inc_s;
                    if (load_last || (count_inc_s == DEPTH_C)) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (reload) begin
                    state_d = ST_LOAD;
                    count_d = (ADDR_WIDTH + 1)'(0);
                end else if (fetch_en) begin
                    state_d = ST_RUN;
                    valid_d = 1'b1;
                    fault_d = fault_s;
                    code_d  = fault_s ? NOP_WORD : word_s;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                count_d = (ADDR_WIDTH + 1)'(0);
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            count_q <= (ADDR_WIDTH + 1)'(0);
            code_q  <= NOP_WORD;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    // Storage array is deliberately not reset; stale bytes are masked by the fault rule.
    always_ff @(posedge clk) begin
        if (xfer_s) begin
            mem[count_q[ADDR_WIDTH-1:0]] <= load_data;
        end
    end

    assign Instruction_Code = code_q;
    assign instr_valid      = valid_q;
    assign fetch_fault      = fault_q;
    assign load_count       = count_q;

endmodule

// File: tb/tb_program_memory.sv
// Self-checking bench for program_memory: table-driven fetch vectors with a
// scoreboard queue, plus hand-written load, reload, reset and full-memory sequences.
module tb_program_memory;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;

    logic        load_valid, load_last, load_ready, reload, fetch_en;
    logic [7:0]  load_data;
    logic [9:0]  pc;
    logic [31:0] code;
    logic        ivalid, ifault, mready;
    logic [10:0] lcount;

    logic        s_load_valid, s_load_last, s_load_ready, s_reload, s_fetch_en;
    logic [7:0]  s_load_data;
    logic [3:0]  s_pc;
    logic [31:0] s_code;
    logic        s_ivalid, s_ifault, s_mready;
    logic [4:0]  s_lcount;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [9:0]  pc;
        logic [31:0] code;
        logic        fault;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] code;
        logic        chk_code;
        logic        valid;
        logic        fault;
    } exp_t;

    vec_t       vecs[12];
    exp_t       sb_q[$];
    logic [7:0] img[32];
    logic [7:0] simg[16];

    always #5 clk = ~clk;

    program_memory u_dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .reload(reload), .fetch_en(fetch_en), .PC(pc),
        .Instruction_Code(code), .instr_valid(ivalid), .fetch_fault(ifault),
        .mem_ready(mready), .load_count(lcount)
    );

    program_memory #(.ADDR_WIDTH(4)) u_small (
        .clk(clk), .reset(reset),
        .load_valid(s_load_valid), .load_data(s_load_data), .load_last(s_load_last),
        .load_ready(s_load_ready), .reload(s_reload), .fetch_en(s_fetch_en), .PC(s_pc),
        .Instruction_Code(s_code), .instr_valid(s_ivalid), .fetch_fault(s_ifault),
        .mem_ready(s_mready), .load_count(s_lcount)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_fetch(input string name, input logic [31:0] c, input logic cc,
                              input logic v, input logic f);
        exp_t e;
        e.name = name; e.code = c; e.chk_code = cc; e.valid = v; e.fault = f;
        sb_q.push_back(e);
    endtask

    // Advance one clock, then retire any expectation queued for this edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({e.name, "_valid"}, {31'd0, ivalid}, {31'd0, e.valid});
            chk({e.name, "_fault"}, {31'd0, ifault}, {31'd0, e.fault});
            if (e.chk_code) chk({e.name, "_code"}, code, e.code);
        end
    endtask

    task automatic set_word(input int w, input logic [31:0] v);
        for (int k = 0; k < 4; k++) img[4*w+k] = v[8*k +: 8];
    endtask

    task automatic set_sword(input int w, input logic [31:0] v);
        for (int k = 0; k < 4; k++) simg[4*w+k] = v[8*k +: 8];
    endtask

    // Stream img[start..n-1]; optionally random valid gaps and fetches during load.
    task automatic load_main(input int start, input int n, input bit rnd,
                             input bit fdur, input bit use_last);
        int i;
        int guard;
        bit v;
        i = start;
        guard = 0;
        while (i < n && guard < 2000) begin
            v          = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            load_valid = v;
            load_data  = v ? img[i] : 8'($urandom_range(0, 255));
            load_last  = v ? (use_last && (i == n - 1)) : (rnd ? 1'($urandom_range(0, 1)) : 1'b0);
            fetch_en   = fdur ? 1'($urandom_range(0, 1)) : 1'b0;
            pc         = 10'd0;
            if (fetch_en) push_fetch("fetch_in_load", 32'd0, 1'b0, 1'b0, 1'b0);
            tick();
            if (v) i++;
            guard++;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        fetch_en   = 1'b0;
        chk("load_complete", i, n);
    endtask

    task automatic load_small(input int start, input int n, input bit use_last);
        for (int i = start; i < n; i++) begin
            s_load_valid = 1'b1;
            s_load_data  = simg[i];
            s_load_last  = use_last && (i == n - 1);
            tick();
        end
        s_load_valid = 1'b0;
        s_load_last  = 1'b0;
    endtask

    task automatic fetch_main(input string name, input logic [9:0] a,
                              input logic [31:0] c, input logic f);
        fetch_en = 1'b1;
        pc       = a;
        push_fetch(name, c, 1'b1, 1'b1, f);
        tick();
        fetch_en = 1'b0;
    endtask

    task automatic fetch_small(input string name, input logic [3:0] a,
                               input logic [31:0] c, input logic f);
        s_fetch_en = 1'b1;
        s_pc       = a;
        tick();
        s_fetch_en = 1'b0;
        chk({name, "_valid"}, {31'd0, s_ivalid}, 32'd1);
        chk({name, "_fault"}, {31'd0, s_ifault}, {31'd0, f});
        chk({name, "_code"}, s_code, c);
    endtask

    task automatic run_table();
        for (int k = 0; k < 12; k++) begin
            fetch_en = 1'b1;
            pc       = vecs[k].pc;
            push_fetch($sformatf("vec%0d", k), vecs[k].code, 1'b1, 1'b1, vecs[k].fault);
            tick();
        end
        fetch_en = 1'b0;
        tick();
        chk("idle_valid", {31'd0, ivalid}, 32'd0);
        chk("idle_fault", {31'd0, ifault}, 32'd0);
        chk("idle_hold_code", code, vecs[11].code);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{10'd0,    32'h00400293, 1'b0};
        vecs[1]  = '{10'd4,    32'h00900313, 1'b0};
        vecs[2]  = '{10'd8,    32'h00c000ef, 1'b0};
        vecs[3]  = '{10'd20,   32'h006283b3, 1'b0};
        vecs[4]  = '{10'd2,    NOP,          1'b1};
        vecs[5]  = '{10'd24,   NOP,          1'b1};
        vecs[6]  = '{10'd20,   32'h006283b3, 1'b0};
        vecs[7]  = '{10'd1,    NOP,          1'b1};
        vecs[8]  = '{10'd1020, NOP,          1'b1};
        vecs[9]  = '{10'd1023, NOP,          1'b1};
        vecs[10] = '{10'd12,   32'h00e00293, 1'b0};
        vecs[11] = '{10'd16,   32'h01000313, 1'b0};

        reset = 1'b1;
        load_valid = 1'b0; load_last = 1'b0; load_data = 8'd0; reload = 1'b0;
        fetch_en = 1'b0; pc = 10'd0;
        s_load_valid = 1'b0; s_load_last = 1'b0; s_load_data = 8'd0; s_reload = 1'b0;
        s_fetch_en = 1'b0; s_pc = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_load_count", {21'd0, lcount}, 32'd0);
        chk("rst_load_ready", {31'd0, load_ready}, 32'd0);
        chk("rst_mem_ready", {31'd0, mready}, 32'd0);
        chk("rst_code", code, NOP);
        chk("rst_valid", {31'd0, ivalid}, 32'd0);
        chk("rst_fault", {31'd0, ifault}, 32'd0);
        chk("rst_small_ready", {31'd0, s_load_ready}, 32'd0);

        reset = 1'b0;
        tick();
        chk("load_open_ready", {31'd0, load_ready}, 32'd1);
        chk("load_open_mem_ready", {31'd0, mready}, 32'd0);

        set_word(0, 32'h00400293); set_word(1, 32'h00900313); set_word(2, 32'h00c000ef);
        set_word(3, 32'h00e00293); set_word(4, 32'h01000313); set_word(5, 32'h006283b3);
        load_main(0, 23, 1'b0, 1'b1, 1'b0);
        chk("pre_last_count", {21'd0, lcount}, 32'd23);
        chk("pre_last_mem_ready", {31'd0, mready}, 32'd0);
        load_main(23, 24, 1'b0, 1'b0, 1'b1);
        chk("loaded_count", {21'd0, lcount}, 32'd24);
        chk("loaded_mem_ready", {31'd0, mready}, 32'd1);
        chk("loaded_load_ready", {31'd0, load_ready}, 32'd0);
        run_table();

        // reload wins over a same-cycle fetch
        reload = 1'b1; fetch_en = 1'b1; pc = 10'd0;
        push_fetch("reload_fetch", 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        reload = 1'b0; fetch_en = 1'b0;
        chk("reload_mem_ready", {31'd0, mready}, 32'd0);
        chk("reload_count", {21'd0, lcount}, 32'd0);
        chk("reload_load_ready", {31'd0, load_ready}, 32'd1);
        chk("reload_hold_code", code, 32'h01000313);

        load_main(0, 24, 1'b1, 1'b1, 1'b1);
        chk("rnd_count", {21'd0, lcount}, 32'd24);
        chk("rnd_mem_ready", {31'd0, mready}, 32'd1);
        run_table();

        reload = 1'b1; tick(); reload = 1'b0;
        set_word(0, 32'h00000073);
        load_main(0, 4, 1'b0, 1'b0, 1'b1);
        chk("ecall_count", {21'd0, lcount}, 32'd4);
        fetch_main("ecall_pc0", 10'd0, 32'h00000073, 1'b0);
        fetch_main("ecall_pc4", 10'd4, NOP, 1'b1);
        fetch_main("stale_pc8", 10'd8, NOP, 1'b1);
        fetch_main("ecall_again", 10'd0, 32'h00000073, 1'b0);

        // asynchronous reset in the middle of a load
        reload = 1'b1; tick(); reload = 1'b0;
        load_main(0, 10, 1'b0, 1'b0, 1'b0);
        chk("partial_count", {21'd0, lcount}, 32'd10);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_count", {21'd0, lcount}, 32'd0);
        chk("async_rst_load_ready", {31'd0, load_ready}, 32'd0);
        chk("async_rst_mem_ready", {31'd0, mready}, 32'd0);
        chk("async_rst_code", code, NOP);
        chk("async_rst_valid", {31'd0, ivalid}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        set_word(0, 32'h00a00093); set_word(1, 32'h00108133);
        load_main(0, 8, 1'b0, 1'b0, 1'b1);
        chk("img8_count", {21'd0, lcount}, 32'd8);
        fetch_main("img8_pc4", 10'd4, 32'h00108133, 1'b0);
        fetch_main("img8_pc8", 10'd8, NOP, 1'b1);
        fetch_main("img8_pc0", 10'd0, 32'h00a00093, 1'b0);

        // 16-byte memory: fill without load_last
        set_sword(0, 32'h00100093); set_sword(1, 32'h00200113);
        set_sword(2, 32'h00300193); set_sword(3, 32'h00400213);
        load_small(0, 15, 1'b0);
        chk("small_pre_full_count", {27'd0, s_lcount}, 32'd15);
        chk("small_pre_full_mem_ready", {31'd0, s_mready}, 32'd0);
        chk("small_pre_full_load_ready", {31'd0, s_load_ready}, 32'd1);
        load_small(15, 16, 1'b0);
        chk("small_full_count", {27'd0, s_lcount}, 32'd16);
        chk("small_full_mem_ready", {31'd0, s_mready}, 32'd1);
        chk("small_full_load_ready", {31'd0, s_load_ready}, 32'd0);
        s_load_valid = 1'b1; s_load_data = 8'hff; tick(); s_load_valid = 1'b0;
        chk("small_extra_count", {27'd0, s_lcount}, 32'd16);
        fetch_small("small_pc12", 4'd12, 32'h00400213, 1'b0);
        fetch_small("small_pc14", 4'd14, NOP, 1'b1);
        fetch_small("small_pc0", 4'd0, 32'h00100093, 1'b0);

        // load_last on the filling transfer
        s_reload = 1'b1; tick(); s_reload = 1'b0;
        chk("small_reload_count", {27'd0, s_lcount}, 32'd0);
        chk("small_reload_mem_ready", {31'd0, s_mready}, 32'd0);
        load_small(0, 16, 1'b1);
        chk("small_last_full_count", {27'd0, s_lcount}, 32'd16);
        chk("small_last_full_mem_ready", {31'd0, s_mready}, 32'd1);
        tick();
        chk("small_stay_run", {31'd0, s_mready}, 32'd1);
        chk("small_stay_load_ready", {31'd0, s_load_ready}, 32'd0);
        fetch_small("small_last_pc12", 4'd12, 32'h00400213, 1'b0);

        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
